// File: rtl/fix_serializer.sv
// FIX transmit serializer: turns tag/value byte fields into a raw FIX byte stream.
// Optional "10=NNN" checksum trailer is enabled by defining FIX_CHECKSUM_EN.
module fix_serializer #(
  parameter logic [7:0] SOH_C    = 8'h01,
  parameter logic [7:0] SEP_C    = 8'h3D,
  parameter bit         LEAD_SOH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  input  logic       in_msg_end,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err_o
);

`ifdef FIX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEAD, TAG, SEP, VALUE, DELIM, TRAILER} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEAD, TAG, SEP, VALUE, DELIM} state_t;
`endif

  state_t     state;
  logic       msg_end;
  logic       can_load, illegal, accept, emit, ld;
  logic [7:0] ld_byte;

  assign can_load = !out_valid || out_ready;
  assign busy     = (state != IDLE) || out_valid;
  assign accept   = in_valid && in_ready;
  assign emit     = accept && !illegal;

  always_comb begin
    illegal = (in_data == SOH_C);
    case (state)
      IDLE, TAG: illegal = illegal || in_kind || (in_data == SEP_C);
      VALUE:     illegal = illegal || !in_kind;
      default:   ;
    endcase
  end

  // With a leading SOH, a legal first tag byte is left waiting on the bus
  // until TAG; only illegal bytes are taken (and dropped) in IDLE.
  always_comb begin
    in_ready = 1'b0;
    if (rst && can_load)
      case (state)
        IDLE:       in_ready = !(LEAD_SOH && in_valid && !illegal);
        TAG, VALUE: in_ready = 1'b1;
        default:    ;
      endcase
  end

`ifdef FIX_CHECKSUM_EN
  logic [7:0] acc, rem_h, trl_byte;
  logic [1:0] dig_h;
  logic [3:0] dig_t, dig_u;
  logic [2:0] trl_idx;

  // Decimal digits by compare/subtract; ascending scan keeps the largest tens match.
  always_comb begin
    dig_h = 2'd0;
    rem_h = acc;
    if (acc >= 8'd200) begin
      dig_h = 2'd2;
      rem_h = acc - 8'd200;
    end else if (acc >= 8'd100) begin
      dig_h = 2'd1;
      rem_h = acc - 8'd100;
    end
    dig_t = 4'd0;
    dig_u = rem_h[3:0];
    for (int k = 1; k <= 9; k++)
      if (rem_h >= 8'(k * 10)) begin
        dig_t = 4'(k);
        dig_u = 4'(rem_h - 8'(k * 10));
      end
    case (trl_idx)
      3'd0:    trl_byte = 8'h31;
      3'd1:    trl_byte = 8'h30;
      3'd2:    trl_byte = SEP_C;
      3'd3:    trl_byte = {6'b001100, dig_h};
      3'd4:    trl_byte = {4'h3, dig_t};
      3'd5:    trl_byte = {4'h3, dig_u};
      default: trl_byte = SOH_C;
    endcase
  end
`endif

  always_comb begin
    ld      = 1'b0;
    ld_byte = in_data;
    case (state)
      IDLE:        ld = !LEAD_SOH && emit;
      LEAD, DELIM: begin ld = can_load; ld_byte = SOH_C; end
      TAG, VALUE:  ld = emit;
      SEP:         begin ld = can_load; ld_byte = SEP_C; end
`ifdef FIX_CHECKSUM_EN
      TRAILER:     begin ld = can_load; ld_byte = trl_byte; end
`endif
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      err_o     <= 1'b0;
      msg_end   <= 1'b0;
`ifdef FIX_CHECKSUM_EN
      acc       <= 8'h00;
      trl_idx   <= 3'd0;
`endif
    end else begin
      err_o <= accept && illegal;
      if (can_load) out_valid <= 1'b0;
      if (ld) begin
        out_data  <= ld_byte;
        out_valid <= 1'b1;
      end
`ifdef FIX_CHECKSUM_EN
      if (ld && state != TRAILER) acc <= acc + ld_byte;
`endif
      case (state)
        IDLE:
          if (LEAD_SOH) begin
            if (in_valid && !illegal) state <= LEAD;
          end else if (emit) state <= in_last ? SEP : TAG;
        LEAD:  if (can_load) state <= TAG;
        TAG:   if (emit && in_last) state <= SEP;
        SEP:   if (can_load) state <= VALUE;
        VALUE:
          if (emit && in_last) begin
            state   <= DELIM;
            msg_end <= in_msg_end;
          end
        DELIM:
          if (can_load) begin
`ifdef FIX_CHECKSUM_EN
            state <= msg_end ? TRAILER : TAG;
`else
            state <= msg_end ? IDLE : TAG;
`endif
          end
`ifdef FIX_CHECKSUM_EN
        TRAILER:
          if (can_load) begin
            trl_idx <= trl_idx + 3'd1;
            if (trl_idx == 3'd6) begin
              trl_idx <= 3'd0;
              acc     <= 8'h00;
              state   <= IDLE;
            end
          end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_serializer.sv
// Directed bench for fix_serializer (default params); trailer expectations follow FIX_CHECKSUM_EN.
module tb_fix_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_kind = 1'b0, in_last = 1'b0, in_msg_end = 1'b0, in_valid = 1'b0;
  logic       in_ready, out_valid, busy, err_o;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;

  int vec = 0, miss = 0, errs = 0, e0;
  logic [7:0] got[$], exp[$], exp1[$], exp2[$];

`ifdef FIX_CHECKSUM_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 1;
`endif

  fix_serializer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_kind(in_kind), .in_last(in_last),
    .in_msg_end(in_msg_end), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (err_o) errs++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    vec++;
    assert (obs === want) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic send(input logic k, input logic [7:0] d, input logic l, input logic m);
    int n = 0;
    in_valid = 1'b1; in_kind = k; in_data = d; in_last = l; in_msg_end = m;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept", {7'd0, in_ready}, 8'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("busy_fall", {7'd0, busy}, 8'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_len"}, 8'(got.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(tag, got[i], exp[i]);
    got.delete();
  endtask

  task automatic msg1();
    send(1'b0, 8'h33, 1'b0, 1'b0);
    send(1'b0, 8'h35, 1'b1, 1'b0);
    send(1'b1, 8'h44, 1'b1, 1'b1);
  endtask

  initial begin
    exp1 = {8'h01, 8'h33, 8'h35, 8'h3D, 8'h44, 8'h01};
    exp2 = {8'h01, 8'h33, 8'h35, 8'h3D, 8'h44, 8'h01, 8'h31, 8'h31, 8'h3D, 8'h37, 8'h01};
`ifdef FIX_CHECKSUM_EN
    exp1 = {exp1, 8'h31, 8'h30, 8'h3D, 8'h32, 8'h33, 8'h35, 8'h01};
    exp2 = {exp2, 8'h31, 8'h30, 8'h3D, 8'h31, 8'h39, 8'h34, 8'h01};
`endif

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_err", {7'd0, err_o}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    got.delete();

    // single field message; in_ready low through DELIM (and trailer)
    e0 = errs;
    msg1();
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {7'd0, in_ready}, 8'd0);
    end
    wait_idle();
    exp = exp1; check_q("msg1");
    chk("msg1_err", 8'(errs - e0), 8'd0);

    // two fields, no leading SOH before the second
    send(1'b0, 8'h33, 1'b0, 1'b0);
    send(1'b0, 8'h35, 1'b1, 1'b0);
    send(1'b1, 8'h44, 1'b1, 1'b0);
    send(1'b0, 8'h31, 1'b0, 1'b0);
    send(1'b0, 8'h31, 1'b1, 1'b0);
    send(1'b1, 8'h37, 1'b1, 1'b1);
    wait_idle();
    exp = exp2; check_q("msg2");

    // downstream stall mid-tag
    send(1'b0, 8'h33, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_kind = 1'b0; in_data = 8'h35; in_last = 1'b1; in_msg_end = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", out_data, 8'h33);
      chk("stall_valid", {7'd0, out_valid}, 8'd1);
      chk("stall_in_ready", {7'd0, in_ready}, 8'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1'b0, 8'h35, 1'b1, 1'b0);
    send(1'b1, 8'h44, 1'b1, 1'b1);
    wait_idle();
    exp = exp1; check_q("stall");

    // illegal bytes in IDLE are dropped
    e0 = errs;
    send(1'b1, 8'h41, 1'b1, 1'b0);
    send(1'b0, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_err", 8'(errs - e0), 8'd2);
    chk("idle_out", 8'(got.size()), 8'd0);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_in_ready", {7'd0, in_ready}, 8'd1);
    @(posedge clk); #1;

    // '=' with in_last inside a tag is dropped and does not end the tag
    e0 = errs;
    send(1'b0, 8'h33, 1'b0, 1'b0);
    send(1'b0, 8'h3D, 1'b1, 1'b0);
    send(1'b0, 8'h35, 1'b1, 1'b0);
    send(1'b1, 8'h44, 1'b1, 1'b1);
    wait_idle();
    exp = exp1; check_q("tag_sep");
    chk("tag_sep_err", 8'(errs - e0), 8'd1);

    // reset mid-value, then a fresh message
    send(1'b0, 8'h33, 1'b0, 1'b0);
    send(1'b0, 8'h35, 1'b1, 1'b0);
    send(1'b1, 8'h44, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_in_ready", {7'd0, in_ready}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    got.delete();
    msg1();
    wait_idle();
    exp = exp1; check_q("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/fix_serializer.md
Name: fix_serializer

Overview:
- Transmit-side counterpart of the FIX field parser: turns a field-structured byte stream (tag bytes, value bytes, field/message boundaries) into a raw FIX byte stream.
- Inserts the '=' separator after each tag and an SOH after each value. Optionally emits a leading SOH per message and a "10=NNN" checksum trailer.
- Sits between the order-building logic and the line/MAC byte interface. Its output stream is legal input for the parser.

Parameters:
- SOH_C, 8'h01, field delimiter byte.
- SEP_C, 8'h3D, tag/value separator byte ('=').
- LEAD_SOH, 1, 1 = emit SOH before the first tag of every message; 0 = no leading SOH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next rising clk).
- in_data  in  8  tag or value byte.
- in_kind  in  1  0 = tag byte, 1 = value byte.
- in_last  in  1  last byte of the current tag or value.
- in_msg_end  in  1  with in_kind=1 and in_last=1: this value closes the message.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- out_data  out  8  serialized byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- busy  out  1  high from the first accepted byte of a message until its final SOH (or trailer SOH) is accepted downstream.
- err_o  out  1  one-cycle pulse on a dropped illegal input byte.

Behaviour:
- Reset values (rst==0):
  - out_valid=0, out_data=8'h00, in_ready=0, busy=0, err_o=0.
  - State IDLE; checksum accumulator cleared.
- Output register:
  - Single output register; out_data/out_valid are registered.
  - The register may load only when !out_valid || out_ready.
  - While out_valid && !out_ready, out_data is held stable.
  - Latency: an accepted input byte appears on out_data the next cycle. Full throughput is 1 byte/cycle when out_ready is held high.
- in_ready is high only in IDLE, TAG or VALUE, and only when the output register can load.
- States and transitions:
  - IDLE: wait for a tag byte (in_kind=0).
    - With LEAD_SOH=1, go to LEAD, holding that byte uncommitted (in_ready stays 0 while in LEAD).
    - With LEAD_SOH=0, accept the byte directly as in TAG.
  - LEAD: emit SOH_C, then go to TAG.
  - TAG: each accepted tag byte is emitted. When in_last=1, go to SEP.
  - SEP: emit SEP_C (in_ready=0), then go to VALUE.
  - VALUE: each accepted value byte is emitted. When in_last=1, go to DELIM and latch in_msg_end.
  - DELIM: emit SOH_C.
    - If latched msg_end=1, go to TRAILER (feature on) or IDLE (feature off).
    - If msg_end=0, go to TAG.
- Illegal input is accepted and dropped: not emitted, state unchanged, err_o pulses one cycle. Illegal input is:
  - a value byte in IDLE or TAG;
  - a tag byte in VALUE;
  - SOH_C anywhere;
  - SEP_C in a tag.
- A dropped byte with in_last=1 does not end the field.
- Empty fields cannot occur: a field always contains the byte carrying in_last.
- Checksum: 8-bit sum, mod 256, of every byte loaded into out_data in the current message, inserted bytes included (leading SOH, '=', SOH), up to and including the final DELIM SOH. Cleared on entry to IDLE.
- Reset mid-message: the message is abandoned; no partial completion, no trailer.
- busy is combinationally equal to (state != IDLE) || out_valid.

Optional Feature:
- Macro: FIX_CHECKSUM_EN.
- Defined: after the final DELIM, the TRAILER sub-sequence emits '1','0','=', then three zero-padded ASCII decimal digits of the checksum (hundreds, tens, units), then SOH_C. That is 7 bytes, in_ready=0 throughout, then return to IDLE.
  - The trailer bytes are not added to the checksum.
  - Digit conversion: compare/subtract against 200/100 and then 90..10. No divider.
- Undefined: no TRAILER states and no accumulator; DELIM with msg_end goes straight to IDLE.

Test Plan:
- LEAD_SOH=1, feature off, out_ready=1; tag "35" (in_last on '5'), value "D" with in_msg_end -> out bytes 01 33 35 3D 44 01. busy falls after the last 01. err_o never pulses.
- Same stimulus with FIX_CHECKSUM_EN -> 01 33 35 3D 44 01 31 30 3D 32 33 35 01 (sum 235). in_ready=0 during the 7 trailer bytes.
- Two fields "35"="D" then "11"="7" with msg_end on the second -> 01 33 35 3D 44 01 31 31 3D 37 01. No leading SOH before the second field.
- out_ready low for 3 cycles mid-tag -> out_data and out_valid held stable, in_ready=0, no byte lost or duplicated. Stream resumes in order.
- In IDLE drive in_kind=1 byte 0x41, then a tag byte 0x01 -> err_o pulses once per byte, no output, state stays IDLE.
- rst=0 while in VALUE with out_valid=1 -> next cycle out_valid=0, busy=0, in_ready=0. After release, a new message starts with a leading 01 and a checksum restarting from 0.
